// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war game: playfield state encoding and
// default bar geometry. Also imported by the victory/score stage.
package tug_pkg;

    typedef enum logic {
        PLAY = 1'b0,
        WON  = 1'b1
    } field_state_t;

    // Default bar length and start/restart position (positions are 1-based).
    localparam int N_LED_DEF  = 9;
    localparam int CENTER_DEF = 5;

endpackage : tug_pkg

// File: rtl/key_conditioner.sv
// Conditions one asynchronous player key: two-flop synchronizer followed by
// a rising-edge detector, giving a clean level and a single-cycle press pulse.
module key_conditioner (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronizer chain plus edge-detect history; history keeps running in every game state.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the value
            // from before this edge, so the chain really is three stages deep.
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign level = sync2;
    assign pulse = sync2 & ~prev;

endmodule : key_conditioner

// File: rtl/tug_playfield.sv
// Playfield stage: conditions both keys, moves a single lit position along
// the LED bar on each press, freezes the bar once a player pulls past an end,
// and recentres when the victory stage requests a restart.
module tug_playfield
    import tug_pkg::*;
#(
    parameter int N_LED  = N_LED_DEF,
    parameter int CENTER = CENTER_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Lraw,
    input  logic             Rraw,
    input  logic             restartGame,
    output logic             L,
    output logic             R,
    output logic [N_LED:1]   LED,
    output logic             frozen
);

    // Positions held in a 4-bit register; bounds pre-sized to match it.
    localparam logic [3:0] POS_CENTER = 4'(CENTER);
    localparam logic [3:0] POS_LEFT   = 4'(N_LED);
    localparam logic [3:0] POS_RIGHT  = 4'd1;

    logic         Lp;
    logic         Rp;
    field_state_t state;
    field_state_t state_next;
    logic [3:0]   pos;
    logic [3:0]   pos_next;

    key_conditioner u_key_l (
        .Clock (Clock),
        .Reset (Reset),
        .raw   (Lraw),
        .level (L),
        .pulse (Lp)
    );

    key_conditioner u_key_r (
        .Clock (Clock),
        .Reset (Reset),
        .raw   (Rraw),
        .level (R),
        .pulse (Rp)
    );

    // State and position registers; reset overrides restart and key pulses.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= PLAY;
            pos   <= POS_CENTER;
        end else begin
            state <= state_next;
            pos   <= pos_next;
        end
    end

    // Next state/position: restart first, then simultaneous presses cancel, then single moves.
    always_comb begin
        // NOTE: defaulting every output of this block up front means no path
        // leaves it unassigned, so no latch is inferred.
        state_next = state;
        pos_next   = pos;
        unique case (state)
            PLAY: begin
                if (restartGame) begin
                    pos_next = POS_CENTER;
                end else if (Lp && Rp) begin
                    pos_next = pos;
                end else if (Lp) begin
                    if (pos == POS_LEFT) begin
                        state_next = WON;
                    end else begin
                        pos_next = pos + 4'd1;
                    end
                end else if (Rp) begin
                    if (pos == POS_RIGHT) begin
                        state_next = WON;
                    end else begin
                        pos_next = pos - 4'd1;
                    end
                end
            end
            WON: begin
                // Bar is frozen with the end LED lit until the victory stage restarts.
                if (restartGame) begin
                    state_next = PLAY;
                    pos_next   = POS_CENTER;
                end
            end
            default: begin
                state_next = PLAY;
                pos_next   = POS_CENTER;
            end
        endcase
    end

    // Moore output: frozen while the game is won.
    always_comb begin
        frozen = (state == WON);
    end

    // One-hot decode of the position onto the bar.
    always_comb begin
        LED = '0;
        for (int i = 1; i <= N_LED; i++) begin
            LED[i] = (pos == 4'(i));
        end
    end

endmodule : tug_playfield
